// File: rtl/bsg_manycore_tile_reset_sequencer_if.sv
// Reset/coordinate bundle between the column reset sequencer and its tile column plus software requester.
// master = sequencer side; slave = consumer side (tiles and soft-reset requester).
interface bsg_manycore_tile_reset_sequencer_if #(
  parameter int num_tiles_y_p  = 8,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7
);
  logic [x_cord_width_p-1:0]               origin_x_i;
  logic [y_cord_width_p-1:0]               origin_y_i;
  logic                                    soft_reset_v_i;
  logic                                    soft_reset_ready_o;
  logic [num_tiles_y_p-1:0]                tile_reset_o;
  logic [x_cord_width_p-1:0]               global_x_o;
  logic [num_tiles_y_p*y_cord_width_p-1:0] global_y_o;
  logic                                    done_o;

  modport master (
    input  origin_x_i, origin_y_i, soft_reset_v_i,
    output soft_reset_ready_o, tile_reset_o, global_x_o, global_y_o, done_o
  );

  modport slave (
    output origin_x_i, origin_y_i, soft_reset_v_i,
    input  soft_reset_ready_o, tile_reset_o, global_x_o, global_y_o, done_o
  );
endinterface

// File: rtl/bsg_manycore_tile_reset_sequencer.sv
// Staggered per-row reset release and coordinate latch for one tile column; row r leaves reset
// (r+1)*stagger_cycles_p cycles after sync reset release. Soft reset accepted only when done (ready == done).
module bsg_manycore_tile_reset_sequencer #(
  parameter int num_tiles_y_p    = 8,
  parameter int x_cord_width_p   = 7,
  parameter int y_cord_width_p   = 7,
  parameter int stagger_cycles_p = 4,
  parameter int sync_stages_p    = 2
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_manycore_tile_reset_sequencer_if.master seq_if
);

  localparam int cnt_width_lp = (stagger_cycles_p > 1) ? $clog2(stagger_cycles_p) : 1;
  localparam int row_width_lp = (num_tiles_y_p > 1) ? $clog2(num_tiles_y_p) : 1;
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(stagger_cycles_p - 1);
  localparam logic [row_width_lp-1:0] row_last_lp = row_width_lp'(num_tiles_y_p - 1);

  typedef enum logic [1:0] {eReset, eRelease, eDone, eHold} state_e;

  logic [sync_stages_p-1:0] sync_r;
  logic                     reset_sync;

  // Deassertion is synchronized; assertion still reaches every flop asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_r <= '0;
    else            sync_r <= {sync_r[sync_stages_p-2:0], 1'b1};
  end

  assign reset_sync = sync_r[sync_stages_p-1];

  state_e                                  state_r, state_n;
  logic [cnt_width_lp-1:0]                 cnt_r, cnt_n;
  logic [row_width_lp-1:0]                 row_r, row_n;
  logic [num_tiles_y_p-1:0]                tile_reset_r, tile_reset_n;
  logic                                    done_r, done_n;
  logic [x_cord_width_p-1:0]               global_x_r, global_x_n;
  logic [num_tiles_y_p*y_cord_width_p-1:0] global_y_r, global_y_n;
  logic [num_tiles_y_p*y_cord_width_p-1:0] y_ladder;

  always_comb begin
    y_ladder = '0;
    for (int r = 0; r < num_tiles_y_p; r++) begin
      y_ladder[r*y_cord_width_p +: y_cord_width_p] = seq_if.origin_y_i + y_cord_width_p'(r);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= eReset;
      cnt_r        <= '0;
      row_r        <= '0;
      tile_reset_r <= '1;
      done_r       <= 1'b0;
      global_x_r   <= '0;
      global_y_r   <= '0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      row_r        <= row_n;
      tile_reset_r <= tile_reset_n;
      done_r       <= done_n;
      global_x_r   <= global_x_n;
      global_y_r   <= global_y_n;
    end
  end

  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    row_n        = row_r;
    tile_reset_n = tile_reset_r;
    done_n       = done_r;
    global_x_n   = global_x_r;
    global_y_n   = global_y_r;

    case (state_r)
      eReset: begin
        if (reset_sync) begin
          global_x_n = seq_if.origin_x_i;
          global_y_n = y_ladder;
          cnt_n      = '0;
          row_n      = '0;
          state_n    = eRelease;
        end
      end

      eRelease: begin
        if (cnt_r == cnt_last_lp) begin
          cnt_n               = '0;
          tile_reset_n[row_r] = 1'b0;
          row_n               = row_r + 1'b1;
          if (row_r == row_last_lp) begin
            row_n   = '0;
            done_n  = 1'b1;
            state_n = eDone;
          end
        end else begin
          cnt_n = cnt_r + 1'b1;
        end
      end

      eDone: begin
        if (seq_if.soft_reset_v_i && done_r) begin
          tile_reset_n = '1;
          done_n       = 1'b0;
          cnt_n        = '0;
          state_n      = eHold;
        end
      end

      eHold: begin
        // Origins are re-sampled only once the hold interval has fully elapsed.
        if (cnt_r == cnt_last_lp) begin
          global_x_n = seq_if.origin_x_i;
          global_y_n = y_ladder;
          cnt_n      = '0;
          row_n      = '0;
          state_n    = eRelease;
        end else begin
          cnt_n = cnt_r + 1'b1;
        end
      end

      default: state_n = eReset;
    endcase
  end

  assign seq_if.tile_reset_o       = tile_reset_r;
  assign seq_if.done_o             = done_r;
  assign seq_if.soft_reset_ready_o = done_r;
  assign seq_if.global_x_o         = global_x_r;
  assign seq_if.global_y_o         = global_y_r;

endmodule

// File: tb/tb_bsg_manycore_tile_reset_sequencer.sv
// Scoreboard bench: expected output-change events are queued when stimulus is applied and
// matched by a monitor whenever the sequencer's reset/done outputs change.
module tb_bsg_manycore_tile_reset_sequencer;

  logic clk;
  logic rst_n;
  logic rst2_n;

  bsg_manycore_tile_reset_sequencer_if #(.num_tiles_y_p(8), .x_cord_width_p(7), .y_cord_width_p(7)) if_a ();
  bsg_manycore_tile_reset_sequencer_if #(.num_tiles_y_p(1), .x_cord_width_p(7), .y_cord_width_p(7)) if_b ();

  bsg_manycore_tile_reset_sequencer #(
    .num_tiles_y_p(8), .x_cord_width_p(7), .y_cord_width_p(7),
    .stagger_cycles_p(4), .sync_stages_p(2)
  ) dut_a (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .seq_if   (if_a.master)
  );

  bsg_manycore_tile_reset_sequencer #(
    .num_tiles_y_p(1), .x_cord_width_p(7), .y_cord_width_p(7),
    .stagger_cycles_p(1), .sync_stages_p(2)
  ) dut_b (
    .clk_i    (clk),
    .reset_n_i(rst2_n),
    .seq_if   (if_b.master)
  );

  typedef struct {
    int         t;
    logic [7:0] rst;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic       mon_en = 1'b0;
  logic [8:0] mon_last = '0;
  int         e0, rise, hs;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [55:0] exp_gy(input logic [6:0] oy);
    logic [55:0] v;
    logic [6:0]  y;
    y = oy;
    for (int r = 0; r < 8; r++) begin
      v[r*7 +: 7] = y;
      y = y + 7'd1;
    end
    return v;
  endfunction

  task automatic push_exp(input int t, input logic [7:0] r, input logic d);
    exp_t e;
    e.t    = t;
    e.rst  = r;
    e.done = d;
    exp_q.push_back(e);
  endtask

  // Queue the eight staggered releases starting from reference edge base.
  task automatic push_releases(input int base, input int rows);
    logic [7:0] m;
    for (int r = 0; r < rows; r++) begin
      m = 8'hFF;
      m = m << (r + 1);
      push_exp(base + (r + 1) * 4, m, (r == 7));
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic release_and_push(input int rise_c, input logic [6:0] ox, input logic [6:0] oy, output int e0_o);
    int n;
    n = 0;
    while (if_a.global_x_o !== ox && n < 10) begin
      tick();
      n++;
    end
    e0_o = cyc;
    check("e0_offset_in_range", 64'((e0_o - rise_c >= 2) && (e0_o - rise_c <= 3)), 64'(1));
    check("gx_latched", 64'(if_a.global_x_o), 64'(ox));
    check("gy_latched", 64'(if_a.global_y_o), 64'(exp_gy(oy)));
    check("rst_still_held_at_e0", 64'(if_a.tile_reset_o), 64'(8'hFF));
    push_releases(e0_o, 8);
    mon_last = {if_a.tile_reset_o, if_a.done_o};
    mon_en   = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && ({if_a.tile_reset_o, if_a.done_o} !== mon_last)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", 64'({if_a.tile_reset_o, if_a.done_o}), 64'(mon_last));
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", 64'(cyc), 64'(e.t));
          check("event_tile_reset", 64'(if_a.tile_reset_o), 64'(e.rst));
          check("event_done", 64'(if_a.done_o), 64'(e.done));
          check("event_ready", 64'(if_a.soft_reset_ready_o), 64'(e.done));
        end
        mon_last = {if_a.tile_reset_o, if_a.done_o};
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    if_a.origin_x_i = 7'd3;
    if_a.origin_y_i = 7'd2;
    if_a.soft_reset_v_i = 1'b0;
    if_b.origin_x_i = 7'd1;
    if_b.origin_y_i = 7'd4;
    if_b.soft_reset_v_i = 1'b0;
    repeat (3) tick();

    check("rst_tile_reset", 64'(if_a.tile_reset_o), 64'(8'hFF));
    check("rst_done", 64'(if_a.done_o), 64'(0));
    check("rst_ready", 64'(if_a.soft_reset_ready_o), 64'(0));
    check("rst_gx", 64'(if_a.global_x_o), 64'(0));
    check("rst_gy", 64'(if_a.global_y_o), 64'(0));
    check("b_rst_tile_reset", 64'(if_b.tile_reset_o), 64'(1));

    // Single row, single-cycle stagger: release and done land on the same edge.
    rst2_n = 1'b1;
    n = 0;
    while (if_b.global_x_o !== 7'd1 && n < 10) begin
      tick();
      n++;
    end
    check("b_gx", 64'(if_b.global_x_o), 64'(1));
    check("b_gy", 64'(if_b.global_y_o), 64'(4));
    check("b_held_at_e0", 64'({if_b.tile_reset_o, if_b.done_o}), 64'(2'b10));
    tick();
    check("b_release_with_done", 64'({if_b.tile_reset_o, if_b.done_o}), 64'(2'b01));

    // Soft reset held high through the whole release: only taken in the first done cycle.
    if_a.soft_reset_v_i = 1'b1;
    rst_n = 1'b1;
    rise = cyc;
    release_and_push(rise, 7'd3, 7'd2, e0);
    hs = e0 + 33;
    push_exp(hs, 8'hFF, 1'b0);
    push_releases(hs + 4, 8);
    repeat (4) tick();
    check("ready_low_in_release", 64'(if_a.soft_reset_ready_o), 64'(0));
    while (cyc < e0 + 32) tick();
    check("done_at_e0_32", 64'(if_a.done_o), 64'(1));
    check("ready_at_e0_32", 64'(if_a.soft_reset_ready_o), 64'(1));
    if_a.origin_x_i = 7'd5;
    if_a.origin_y_i = 7'd126;
    while (cyc < hs + 3) tick();
    check("gx_old_before_h4", 64'(if_a.global_x_o), 64'(3));
    check("gy_old_before_h4", 64'(if_a.global_y_o), 64'(exp_gy(7'd2)));
    tick();
    check("gx_new_at_h4", 64'(if_a.global_x_o), 64'(5));
    check("gy_new_at_h4", 64'(if_a.global_y_o), 64'(exp_gy(7'd126)));
    check("gy_row1_127", 64'(if_a.global_y_o[7 +: 7]), 64'(127));
    check("gy_row2_wrap0", 64'(if_a.global_y_o[14 +: 7]), 64'(0));
    check("gy_row7_wrap5", 64'(if_a.global_y_o[49 +: 7]), 64'(5));
    if_a.soft_reset_v_i = 1'b0;
    wait_drain(60);
    check("done_after_soft", 64'(if_a.done_o), 64'(1));

    // One-cycle soft pulse, then pod reset while tile_reset is 0xF0.
    hs = cyc + 1;
    push_exp(hs, 8'hFF, 1'b0);
    push_releases(hs + 4, 4);
    if_a.soft_reset_v_i = 1'b1;
    tick();
    if_a.soft_reset_v_i = 1'b0;
    wait_drain(40);
    check("tile_reset_f0", 64'(if_a.tile_reset_o), 64'(8'hF0));
    mon_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_tile_reset", 64'(if_a.tile_reset_o), 64'(8'hFF));
    check("async_done", 64'(if_a.done_o), 64'(0));
    check("async_ready", 64'(if_a.soft_reset_ready_o), 64'(0));
    check("async_gx", 64'(if_a.global_x_o), 64'(0));
    check("async_gy", 64'(if_a.global_y_o), 64'(0));
    tick();
    tick();
    if_a.origin_x_i = 7'd3;
    if_a.origin_y_i = 7'd2;
    rst_n = 1'b1;
    rise = cyc;
    release_and_push(rise, 7'd3, 7'd2, e0);
    wait_drain(50);
    check("rerun_done", 64'(if_a.done_o), 64'(1));
    check("rerun_tile_reset", 64'(if_a.tile_reset_o), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
